// File: rtl/unidade_operandos_pkg.sv
// Shared types and constants for the operand unit: FSM states, request targets, op encoding.
package pkg_operandos;

    localparam int unsigned LARGURA_DEF  = 8;
    localparam int unsigned LARG_END_DEF = 9;

    typedef enum logic [2:0] {
        StOcioso,
        StLer,
        StEsp,
        StMult,
        StCalc,
        StFim,
        StEspera
    } estado_e;

    localparam logic [1:0] ALVO_A = 2'd0;
    localparam logic [1:0] ALVO_B = 2'd1;
    localparam logic [1:0] ALVO_C = 2'd2;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/multiplicador_serial.sv
// Repeated-addition multiplier: start loads the count from b_i, then adds a_i once per cycle.
module multiplicador_serial
    import pkg_operandos::*;
#(
    parameter int unsigned LARGURA = LARGURA_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [LARGURA-1:0]     a_i,
    input  logic [LARGURA-1:0]     b_i,
    output logic                   pronto_o,
    output logic [2*LARGURA-1:0]   produto_o
);

    logic [2*LARGURA-1:0] acc_q, acc_d;
    logic [LARGURA-1:0]   cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            acc_d = '0;
            cnt_d = b_i;
        end else if (cnt_q != '0) begin
            acc_d = acc_q + {{LARGURA{1'b0}}, a_i};
            cnt_d = cnt_q - LARGURA'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pronto_o  = (cnt_q == '0);
    assign produto_o = acc_q;

endmodule

// File: rtl/unidade_operandos.sv
// Operand unit: answers EnA/EnB/EnC from the controller, fetches A/B from the ROM and computes C.
module unidade_operandos
    import pkg_operandos::*;
#(
    parameter int unsigned LARGURA  = LARGURA_DEF,
    parameter int unsigned LARG_END = LARG_END_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EnA,
    input  logic                  EnB,
    input  logic                  EnC,
    input  logic [LARG_END-1:0]   Endereco,
    input  logic                  Op,
    input  logic                  SELM,
    output logic [LARG_END-1:0]   rom_end,
    output logic                  rom_le,
    input  logic [LARGURA-1:0]    rom_dado,
    output logic                  FimA,
    output logic                  FimB,
    output logic                  FimC,
    output logic [LARGURA-1:0]    B,
    output logic [2*LARGURA-1:0]  C
);

    estado_e               estado_q, estado_d;
    logic [1:0]            alvo_q, alvo_d;
    logic [LARG_END-1:0]   rom_end_q, rom_end_d;
    logic                  rom_le_q, rom_le_d;
    logic                  fim_a_q, fim_a_d, fim_b_q, fim_b_d, fim_c_q, fim_c_d;
    logic [LARGURA-1:0]    a_q, a_d, b_q, b_d;
    logic [2*LARGURA-1:0]  c_q, c_d;
    logic                  mult_start, mult_pronto;
    logic [2*LARGURA-1:0]  produto, soma, dif;
    logic                  en_alvo;

    multiplicador_serial #(
        .LARGURA (LARGURA)
    ) u_mult (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (mult_start),
        .a_i       (a_q),
        .b_i       (rom_dado),
        .pronto_o  (mult_pronto),
        .produto_o (produto)
    );

    // Full-width difference so A-B is exact over the whole operand range.
    assign soma = {{LARGURA{1'b0}}, a_q} + {{LARGURA{1'b0}}, b_q};
    assign dif  = {{LARGURA{1'b0}}, a_q} - {{LARGURA{1'b0}}, b_q};

    always_comb begin
        case (alvo_q)
            ALVO_A:  en_alvo = EnA;
            ALVO_B:  en_alvo = EnB;
            default: en_alvo = EnC;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        alvo_d     = alvo_q;
        rom_end_d  = rom_end_q;
        rom_le_d   = 1'b0;
        fim_a_d    = 1'b0;
        fim_b_d    = 1'b0;
        fim_c_d    = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        mult_start = 1'b0;
        case (estado_q)
            StOcioso: begin
                if (EnA || EnB) begin
                    alvo_d    = EnA ? ALVO_A : ALVO_B;
                    rom_end_d = Endereco;
                    rom_le_d  = 1'b1;
                    estado_d  = StLer;
                end else if (EnC) begin
                    alvo_d   = ALVO_C;
                    estado_d = StCalc;
                end
            end
            StLer: estado_d = StEsp;
            StEsp: begin
                estado_d = StEspera;
                if (alvo_q == ALVO_A) begin
                    a_d     = rom_dado;
                    fim_a_d = 1'b1;
                end else begin
                    b_d     = rom_dado;
                    fim_b_d = 1'b1;
                    if (SELM && rom_dado != '0) begin
                        mult_start = 1'b1;
                        estado_d   = StMult;
                    end
                end
            end
            StMult: begin
                if (mult_pronto) begin
                    estado_d = StEspera;
                end
            end
            StCalc: begin
                if (SELM) begin
                    c_d = (b_q == '0) ? '0 : produto;
                end else if (Op == OP_SUB) begin
                    c_d = dif;
                end else begin
                    c_d = soma;
                end
                estado_d = StFim;
            end
            StFim: begin
                fim_c_d  = 1'b1;
                estado_d = StEspera;
            end
            StEspera: begin
                // Hold until the originating enable drops, so one request yields one pulse.
                if (!en_alvo) begin
                    estado_d = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= StOcioso;
            alvo_q    <= ALVO_A;
            rom_end_q <= '0;
            rom_le_q  <= 1'b0;
            fim_a_q   <= 1'b0;
            fim_b_q   <= 1'b0;
            fim_c_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            estado_q  <= estado_d;
            alvo_q    <= alvo_d;
            rom_end_q <= rom_end_d;
            rom_le_q  <= rom_le_d;
            fim_a_q   <= fim_a_d;
            fim_b_q   <= fim_b_d;
            fim_c_q   <= fim_c_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
        end
    end

    assign rom_end = rom_end_q;
    assign rom_le  = rom_le_q;
    assign FimA    = fim_a_q;
    assign FimB    = fim_b_q;
    assign FimC    = fim_c_q;
    assign B       = b_q;
    assign C       = c_q;

endmodule
